// File: rtl/insector_sched.sv
`default_nettype none
// ============================================================================
// Module   : insector_sched
// Purpose  : Round-robin scheduler sharing one tri_insector among NREQ ray
//            requesters; optional WAIT watchdog via INSECTOR_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module insector_sched #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*192-1:0] req_ray,
    input  logic [NREQ*32-1:0]  req_baseaddr,
    input  logic [NREQ*32-1:0]  req_tri_cnt,
    output logic [NREQ-1:0]     resp_valid,
    output logic                resp_hit,
    output logic [31:0]         resp_t,
    output logic [31:0]         resp_tri_index,
    output logic                resp_timeout,
    output logic                busy,
    output logic                ins_ivalid,
    output logic [31:0]         ins_baseaddr,
    output logic [191:0]        ins_ray,
    output logic [31:0]         ins_tri_cnt,
    output logic                ins_abort,
    input  logic                ins_hit,
    input  logic [31:0]         ins_t,
    input  logic [31:0]         ins_tri_index,
    input  logic                ins_finish
);

    localparam int                 c_PTR_W   = $clog2(NREQ);
    localparam logic [c_PTR_W:0]   c_NREQ    = (c_PTR_W+1)'(NREQ);
    localparam logic [c_PTR_W-1:0] c_PTR_RST = c_PTR_W'(NREQ - 1);
    localparam logic [31:0]        c_T_MISS  = 32'h7FFF_FFFF;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LAUNCH = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] r_gnt;
    logic [c_PTR_W-1:0] w_sel;
    logic [c_PTR_W:0]   w_cand;
    logic               w_found;
    logic [NREQ-1:0]    w_sel_oh;
    logic [NREQ-1:0]    w_gnt_oh;
    logic [191:0]       w_sel_ray;
    logic [31:0]        w_sel_base;
    logic [31:0]        w_sel_cnt;
    logic               w_wd_expired;

    logic [191:0]       r_ins_ray;
    logic [31:0]        r_ins_baseaddr;
    logic [31:0]        r_ins_tri_cnt;
    logic               r_resp_hit;
    logic [31:0]        r_resp_t;
    logic [31:0]        r_resp_tri_index;
    logic               r_resp_timeout;

    // First valid requester at or after ptr+1, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_cand  = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            w_cand = {1'b0, r_ptr} + (c_PTR_W+1)'(i);
            if (w_cand >= c_NREQ) begin
                w_cand = w_cand - c_NREQ;
            end
            if (!w_found && req_valid[w_cand[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[c_PTR_W-1:0];
            end
        end
    end

    assign w_sel_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
    assign w_gnt_oh   = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
    assign w_sel_ray  = req_ray[int'(w_sel)*192 +: 192];
    assign w_sel_base = req_baseaddr[int'(w_sel)*32 +: 32];
    assign w_sel_cnt  = req_tri_cnt[int'(w_sel)*32 +: 32];

`ifdef INSECTOR_SCHED_TIMEOUT_EN
    logic [31:0] r_wd_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (r_state == c_ST_LAUNCH) begin
            r_wd_cnt <= '0;
        end else if (r_state == c_ST_WAIT) begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
        end
    end

    // A finishing insector always wins over an expiring watchdog.
    assign w_wd_expired = (r_state == c_ST_WAIT) && !ins_finish &&
                          (r_wd_cnt >= TIMEOUT_CYCLES);
`else
    logic [31:0] w_unused_timeout_cycles;
    assign w_unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_wd_expired            = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    // Zero-length batches bypass the insector entirely.
                    w_state_nxt = (w_sel_cnt == 32'd0) ? c_ST_RESP : c_ST_LAUNCH;
                end
            end
            c_ST_LAUNCH: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: begin
                if (ins_finish || w_wd_expired) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP:   w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        ins_ivalid = 1'b0;
        busy       = 1'b1;
        ins_abort  = w_wd_expired;
        case (r_state)
            c_ST_IDLE: begin
                busy = 1'b0;
                if (w_found && !reset) begin
                    req_ready = w_sel_oh;
                end
            end
            c_ST_LAUNCH: ins_ivalid = 1'b1;
            c_ST_RESP:   resp_valid = w_gnt_oh;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr            <= c_PTR_RST;
            r_gnt            <= '0;
            r_ins_ray        <= '0;
            r_ins_baseaddr   <= '0;
            r_ins_tri_cnt    <= '0;
            r_resp_hit       <= 1'b0;
            r_resp_t         <= '0;
            r_resp_tri_index <= '0;
            r_resp_timeout   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_gnt          <= w_sel;
                        r_ins_ray      <= w_sel_ray;
                        r_ins_baseaddr <= w_sel_base;
                        r_ins_tri_cnt  <= w_sel_cnt;
                        if (w_sel_cnt == 32'd0) begin
                            r_resp_hit       <= 1'b0;
                            r_resp_t         <= c_T_MISS;
                            r_resp_tri_index <= '0;
                            r_resp_timeout   <= 1'b0;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (ins_finish) begin
                        r_resp_hit       <= ins_hit;
                        r_resp_t         <= ins_t;
                        r_resp_tri_index <= ins_tri_index;
                        r_resp_timeout   <= 1'b0;
                    end else if (w_wd_expired) begin
                        r_resp_hit       <= 1'b0;
                        r_resp_t         <= c_T_MISS;
                        r_resp_tri_index <= '0;
                        r_resp_timeout   <= 1'b1;
                    end
                end
                c_ST_RESP: r_ptr <= r_gnt;
                default:   ;
            endcase
        end
    end

    assign ins_ray        = r_ins_ray;
    assign ins_baseaddr   = r_ins_baseaddr;
    assign ins_tri_cnt    = r_ins_tri_cnt;
    assign resp_hit       = r_resp_hit;
    assign resp_t         = r_resp_t;
    assign resp_tri_index = r_resp_tri_index;
    assign resp_timeout   = r_resp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_insector_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_insector_sched
// Purpose  : Scoreboard bench for insector_sched with a behavioural insector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_insector_sched;

    localparam int NREQ = 4;
    localparam int TO   = 64;
    localparam logic [31:0] c_T_MISS = 32'h7FFF_FFFF;

    typedef struct {
        int          r;
        logic        hit;
        logic [31:0] t;
        logic [31:0] idx;
        logic        to;
        bit          cnt0;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*192-1:0] req_ray;
    logic [NREQ*32-1:0]  req_baseaddr;
    logic [NREQ*32-1:0]  req_tri_cnt;
    logic [NREQ-1:0]     resp_valid;
    logic                resp_hit;
    logic [31:0]         resp_t;
    logic [31:0]         resp_tri_index;
    logic                resp_timeout;
    logic                busy;
    logic                ins_ivalid;
    logic [31:0]         ins_baseaddr;
    logic [191:0]        ins_ray;
    logic [31:0]         ins_tri_cnt;
    logic                ins_abort;
    logic                ins_hit = 1'b0;
    logic [31:0]         ins_t = '0;
    logic [31:0]         ins_tri_index = '0;
    logic                ins_finish = 1'b0;

    insector_sched #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_ray        (req_ray),
        .req_baseaddr   (req_baseaddr),
        .req_tri_cnt    (req_tri_cnt),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_t         (resp_t),
        .resp_tri_index (resp_tri_index),
        .resp_timeout   (resp_timeout),
        .busy           (busy),
        .ins_ivalid     (ins_ivalid),
        .ins_baseaddr   (ins_baseaddr),
        .ins_ray        (ins_ray),
        .ins_tri_cnt    (ins_tri_cnt),
        .ins_abort      (ins_abort),
        .ins_hit        (ins_hit),
        .ins_t          (ins_t),
        .ins_tri_index  (ins_tri_index),
        .ins_finish     (ins_finish)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [191:0] ray_s  [NREQ];
    logic [31:0]  base_s [NREQ];
    logic [31:0]  cnt_s  [NREQ];
    int           rem    [NREQ];
    bit           inflight [NREQ];
    int           gnt_q [$];
    exp_t         exp_q [$];
    bit           force_all;
    bit           model_hang;
    int           model_delay;
    int           acc_cyc = -10;
    int           acc_r   = 0;
    bit           acc_cnt0;
    int           fin_cyc = 0;
    int           n_abort = 0;
    int           n_resp  = 0;
    int           n_launch = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [191:0] ray, input logic [31:0] base,
                           input logic [31:0] cnt);
        ray_s[r]  = ray;
        base_s[r] = base;
        cnt_s[r]  = cnt;
        req_ray[192*r +: 192]    = ray;
        req_baseaddr[32*r +: 32] = base;
        req_tri_cnt[32*r +: 32]  = cnt;
    endtask

    function automatic logic [191:0] mk_ray(input int r);
        mk_ray = {64'h0123_4567_89AB_CDEF, 32'hC0DE_0000 + 32'(r), 32'h5A5A_0000,
                  32'h0002_0000 + 32'(r) * 32'h100, 32'(r & 1)};
    endfunction

    function automatic bit rem_pending();
        rem_pending = 1'b0;
        for (int r = 0; r < NREQ; r++) if (rem[r] > 0) rem_pending = 1'b1;
    endfunction

    task automatic run_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || gnt_q.size() > 0 || exp_q.size() > 0 || rem_pending()) && n < budget);
        check("batches_done_in_budget", n < budget, 1);
    endtask

    // Requesters, insector model and scoreboard; all sampling on the falling edge.
    initial begin : mon
        exp_t e;
        int   g;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++)
                req_valid[r] = force_all || ((rem[r] > 0) && !inflight[r]);
            @(negedge clk);
            if (reset) begin
                ins_finish = 1'b0;
            end else begin
                if (busy) check("ready_while_busy", req_ready, 0);
                if (req_ready != '0) begin
                    g = -1;
                    for (int r = NREQ - 1; r >= 0; r--) if (req_ready[r]) g = r;
                    check("ready_onehot", $countones(req_ready), 1);
                    check("ready_needs_valid", req_ready & ~req_valid, 0);
                    check("grant_expected", gnt_q.size() > 0, 1);
                    if (gnt_q.size() > 0) check("grant_order", g, gnt_q.pop_front());
                    rem[g]--;
                    inflight[g] = 1'b1;
                    acc_cyc  = cyc;
                    acc_r    = g;
                    acc_cnt0 = (cnt_s[g] == 32'd0);
                    e.r = g;
                    e.cnt0 = acc_cnt0;
                    if (acc_cnt0) begin
                        e.hit = 1'b0; e.t = c_T_MISS; e.idx = '0; e.to = 1'b0;
                    end else if (model_hang) begin
                        e.hit = 1'b0; e.t = c_T_MISS; e.idx = '0; e.to = 1'b1;
                    end else begin
                        e.hit = ray_s[g][0];
                        e.t   = base_s[g] + ray_s[g][63:32];
                        e.idx = cnt_s[g] - 32'd2;
                        e.to  = 1'b0;
                    end
                    exp_q.push_back(e);
                end
                if (cyc == acc_cyc + 1) begin
                    check("launch_ivalid", ins_ivalid, !acc_cnt0);
                    check("launch_ray", ins_ray, ray_s[acc_r]);
                    check("launch_base", ins_baseaddr, base_s[acc_r]);
                    check("launch_cnt", ins_tri_cnt, cnt_s[acc_r]);
                end
                if (cyc == acc_cyc + 2) check("ivalid_one_cycle", ins_ivalid, 0);
                if (resp_valid != '0) begin
                    n_resp++;
                    check("resp_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("resp_valid", resp_valid, 4'b0001 << e.r);
                        check("resp_hit", resp_hit, e.hit);
                        check("resp_t", resp_t, e.t);
                        check("resp_idx", resp_tri_index, e.idx);
                        check("resp_timeout", resp_timeout, e.to);
                        check("hold_ray", ins_ray, ray_s[e.r]);
                        if (e.cnt0) check("resp_latency_cnt0", cyc, acc_cyc + 1);
                        else if (!e.to) check("resp_latency", cyc, fin_cyc + 1);
                        inflight[e.r] = 1'b0;
                    end
                end
                if (ins_abort) n_abort++;
                if (ins_ivalid) begin
                    n_launch++;
                    ins_finish = 1'b0;
                    model_run(1'b1);
                end else begin
                    model_run(1'b0);
                end
            end
        end
    end

    bit          m_busy = 1'b0;
    int          m_count;
    logic        m_hit;
    logic [31:0] m_t;
    logic [31:0] m_idx;

    task automatic model_run(input bit launch);
        if (reset || ins_abort) begin
            m_busy = 1'b0;
        end else if (launch) begin
            m_busy  = 1'b1;
            m_count = model_delay;
            m_hit   = ins_ray[0];
            m_t     = ins_baseaddr + ins_ray[63:32];
            m_idx   = ins_tri_cnt - 32'd2;
        end else if (m_busy && !model_hang) begin
            m_count--;
            if (m_count <= 0) begin
                ins_hit       = m_hit;
                ins_t         = m_t;
                ins_tri_index = m_idx;
                ins_finish    = 1'b1;
                fin_cyc       = cyc;
                m_busy        = 1'b0;
            end
        end
    endtask

    initial begin : main
        int l0;
        int r0;
        int a0;
        reset = 1'b1;
        force_all = 1'b1;
        model_hang = 1'b0;
        model_delay = 40;
        req_ray = '0;
        req_baseaddr = '0;
        req_tri_cnt = '0;
        for (int r = 0; r < NREQ; r++) begin
            rem[r] = 0;
            inflight[r] = 1'b0;
            set_req(r, mk_ray(r), 32'h0010_0000 * 32'(r + 1), 32'(r + 3));
        end
        repeat (3) @(negedge clk);
        check("rst_ready_gated", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ins", {ins_ivalid, ins_abort, ins_baseaddr, ins_tri_cnt}, 0);
        check("rst_ins_ray", ins_ray, 0);
        check("rst_resp", {resp_valid, resp_hit, resp_t, resp_tri_index, resp_timeout}, 0);
        force_all = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single request on r1
        set_req(1, {128'hFEED_FACE_0000_1111_2222_3333_4444_5555, 32'h0001_7000, 32'h1},
                32'h0000_1000, 32'd5);
        gnt_q.push_back(1);
        rem[1] = 1;
        run_done(200);
        check("single_hit", resp_hit, 1);
        check("single_t", resp_t, 32'h0001_8000);
        check("single_idx", resp_tri_index, 3);

        // Zero-length batch on r3
        set_req(3, mk_ray(3), 32'h0000_3000, 32'd0);
        gnt_q.push_back(3);
        rem[3] = 1;
        l0 = n_launch;
        run_done(50);
        check("cnt0_no_launch", n_launch, l0);
        check("cnt0_t", resp_t, c_T_MISS);
        set_req(3, mk_ray(3), 32'h0040_0000, 32'd9);

        // Contention r0 / r2
        model_delay = 6;
        rem[0] = 2;
        rem[2] = 2;
        gnt_q.push_back(0); gnt_q.push_back(2); gnt_q.push_back(0); gnt_q.push_back(2);
        run_done(400);

        // Reset in the middle of WAIT
        model_hang = 1'b1;
        gnt_q.push_back(1);
        rem[1] = 1;
        l0 = n_launch;
        for (int n = 0; n < 50 && n_launch == l0; n++) @(negedge clk);
        check("launch_seen", n_launch > l0, 1);
        repeat (5) @(negedge clk);
        r0 = n_resp;
        #1 reset = 1'b1;
        #1;
        check("midrst_outputs", {req_ready, resp_valid, resp_hit, resp_t, resp_tri_index,
              resp_timeout, busy, ins_ivalid, ins_baseaddr, ins_tri_cnt, ins_abort}, 0);
        check("midrst_ray", ins_ray, 0);
        exp_q.delete();
        gnt_q.delete();
        for (int r = 0; r < NREQ; r++) begin
            rem[r] = 0;
            inflight[r] = 1'b0;
        end
        model_hang = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("no_stale_resp", n_resp, r0);

        // All four requesters, two batches each
        model_delay = 4;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < NREQ; r++) gnt_q.push_back(r);
        for (int r = 0; r < NREQ; r++) rem[r] = 2;
        run_done(600);

`ifdef INSECTOR_SCHED_TIMEOUT_EN
        model_hang = 1'b1;
        a0 = n_abort;
        gnt_q.push_back(2);
        rem[2] = 1;
        run_done(300);
        check("abort_pulses", n_abort - a0, 1);
        check("timeout_flag", resp_timeout, 1);
        model_hang = 1'b0;
        gnt_q.push_back(2);
        rem[2] = 1;
        run_done(200);
        check("timeout_cleared", resp_timeout, 0);
`else
        a0 = n_abort;
        check("abort_never", a0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
